pipe_skid_reg: RTL

//  Pipeline boundary register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/pipe_skid_reg_pkg.sv | 21 ++
 rtl/pipe_skid_reg_skid_slot.sv | 37 +++
 rtl/pipe_skid_reg.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg_pkg
//   Shared definitions for the pipeline skid register. The hazard unit also uses
//   the state encoding for stall and debug decoding.
//
//   state_t            : occupancy state of the stage (EMPTY / ONE / TWO)
//   DEFAULT_DATA_WIDTH : default payload width of the stage
// -----------------------------------------------------------------------------
package pipe_skid_reg_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    // The encoding equals the number of held entries, so the count output is
    // simply the state register.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

endpackage : pipe_skid_reg_pkg

// File: rtl/pipe_skid_reg_skid_slot.sv
// -----------------------------------------------------------------------------
// skid_slot
//   Enabled payload register used for the main and skid entries of the stage.
//   The register loads d on a rising edge where en is high. Otherwise it holds
//   its value. Synchronous reset clears it to zero.
//
//   clk : clock
//   rst : synchronous, active-high reset
//   en  : load enable
//   d   : next payload
//   q   : held payload
// -----------------------------------------------------------------------------
module skid_slot #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);

    // NOTE: non-blocking (<=) assignments in clocked blocks make every register
    // sample its inputs before any register updates. That ordering is what makes
    // the main <= skid shift safe.
    // NOTE: this data register is reset on purpose because out_data must read zero
    // after reset. Wide storage that nobody observes before it is written would
    // normally stay unreset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : skid_slot

// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//   Pipeline boundary register with a valid/ready handshake and a 2-entry skid
//   buffer, placed between two processor stages. in_ready is decoded only from
//   the state register, so there is never a combinational path from out_ready to
//   in_ready. flush squashes every held entry, for example on a branch mispredict.
//
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous, active-high reset (has priority over flush)
//   in_valid  : producer presents in_data
//   in_ready  : stage accepts in_data this cycle
//   in_data   : producer payload
//   out_valid : out_data is valid
//   out_ready : consumer takes out_data this cycle
//   out_data  : payload presented to the consumer (always the main slot)
//   flush     : drop all held entries at the next edge (payload regs keep values)
//   count     : number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  flush,
    output logic [1:0]            count
);

    state_t                state_q;
    state_t                state_next;
    logic                  push;
    logic                  pop;
    logic                  main_en;
    logic                  skid_en;
    logic                  main_from_skid;
    logic [DATA_WIDTH-1:0] main_d;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;

    // These outputs depend only on the registered state. This keeps the ready
    // path registered.
    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign count     = state_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_next;
        end
    end

    // NOTE: every signal written here gets a default value first. Then no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next     = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;

        unique case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_next = ST_ONE;
                    main_en    = 1'b1;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    main_en = 1'b1;             // replace the departing word
                end else if (push) begin
                    state_next = ST_TWO;
                    skid_en    = 1'b1;          // park the new word behind main
                end else if (pop) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    state_next     = ST_ONE;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;      // promote the parked word
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase

        // A flush discards held and offered words. The payload registers are
        // left untouched, so no enable reaches them.
        if (flush) begin
            state_next = ST_EMPTY;
            main_en    = 1'b0;
            skid_en    = 1'b0;
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    skid_slot #(.DATA_WIDTH(DATA_WIDTH)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    skid_slot #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

endmodule : pipe_skid_reg
